pid_pwm_out: RTL and testbench
==============================

Name: pid_pwm_out

Overview:
- Downstream stage of the PID controller.
- Consumes the 17-bit controller output uk, already saturated upstream at 15000. Clamps it once more, latches it into a shadow duty register on period boundaries, and drives a fixed-period PWM output pair to the power stage.
- Emits a one-cycle period tick that the system uses as the sampling strobe for the next error value.

Parameters:
- PERIOD, 15000, PWM period in clk cycles; also the maximum duty.
- UK_W, 17, width of the uk input.
- CNT_W, 14, width of the period counter and duty register; must satisfy 2^CNT_W > PERIOD.
- DEAD, 8, dead-time in clk cycles; used only when PID_PWM_DEADTIME_EN is defined.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- en  in  1  run request.
- uk  in  UK_W  controller output; bit UK_W-1 set means negative.
- pwm_h  out  1  high-side drive, registered.
- pwm_l  out  1  low-side drive, registered.
- duty  out  CNT_W  duty value currently in effect (shadow register).
- period_tick  out  1  one-cycle pulse on the last cycle of each period.
- sat  out  1  set when the duty value last latched was clamped.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, cnt=0, duty=0, pwm_h=0, pwm_l=0, period_tick=0, sat=0. Reset overrides everything, including mid-period and mid-dead-time.
- Clamp function clamp(uk), purely combinational:
  - uk[UK_W-1]=1 → 0, clamp flag=1.
  - uk > PERIOD → PERIOD, clamp flag=1.
  - otherwise → uk[CNT_W-1:0], clamp flag=0.
- States:
  - IDLE: cnt=0; pwm_h=0; pwm_l=0; no ticks.
  - IDLE→RUN when en=1. On that edge duty<=clamp(uk), sat<=clamp flag, cnt<=0.
  - RUN: cnt increments by 1 each cycle, wrapping PERIOD-1 → 0.
  - In RUN, when cnt==PERIOD-1: period_tick=1 for that cycle, duty<=clamp(uk), sat<=clamp flag.
  - en is sampled only at cnt==PERIOD-1. If en=0 there, the next state is IDLE, and duty and sat are not updated. Deasserting en mid-period always completes the current period.
  - en=1 and en=0 on the same boundary cycle cannot both occur; only the sampled value matters.
- Duty changes only at period boundaries. uk changes mid-period have no effect until the next boundary.
- PWM generation:
  - pwm_h <= (state==RUN) && (cnt < duty), registered, so it lags cnt by 1 cycle.
  - duty=0 → pwm_h never high.
  - duty=PERIOD → pwm_h continuously high across period boundaries, with no glitch.
  - In RUN, pwm_h is high for exactly duty cycles per period.
  - On RUN→IDLE, pwm_h and pwm_l are 0 from the cycle after the final tick plus the 1-cycle register lag.
- pwm_l without dead-time: pwm_l = registered (state==RUN) && !(cnt < duty). pwm_h and pwm_l are never both 1.
- period_tick is combinational from registered state/cnt: high iff state==RUN and cnt==PERIOD-1.

Optional Feature:
- Macro: PID_PWM_DEADTIME_EN.
- Defined:
  - A rising edge of either output is delayed until the other output has been low for DEAD consecutive cycles. Falling edges are immediate.
  - Each raw high phase is shortened by DEAD cycles at its start. A raw high phase of ≤DEAD cycles produces no pulse.
  - pwm_h and pwm_l are never both 1, and there are always ≥DEAD low-low cycles between them.
  - A dead-time counter of width ≥ clog2(DEAD+1) is cleared by reset and in IDLE.
- Undefined: DEAD is ignored and the dead-time logic is absent. pwm_l is the plain complement of pwm_h while in RUN.

Test Plan (bench overrides PERIOD=20, CNT_W=5, DEAD=2):
1. Reset held 3 cycles with en=1 and uk=10 → all outputs 0 throughout. Release rst_n → IDLE→RUN, duty=10, sat=0; per period pwm_h=1 for exactly 10 cycles and pwm_l=1 for 10; period_tick every 20 cycles.
2. uk=17'h1FFF6 (negative) → duty=0, sat=1, pwm_h always 0. Then uk=25 → at the next boundary duty=20, sat=1, pwm_h constant 1 across two periods.
3. uk changed 5→15 at cnt=7 → current period still has 5 high cycles; the next period has 15 high cycles. duty changes only on the tick edge.
4. en dropped at cnt=3 → period completes, tick at cnt=19, then IDLE with pwm_h=pwm_l=0 and no further ticks. en reasserted → cnt restarts at 0 with a freshly latched duty.
5. rst_n pulsed low 1 cycle at cnt=12 → next cycle all outputs 0, state IDLE. Restart proceeds as in scenario 1.
6. With PID_PWM_DEADTIME_EN, uk=10 → pwm_h high 8 cycles and pwm_l high 8 cycles per period, with 2 low-low cycles at each transition. uk=2 → pwm_h never high.

Source files
------------

// File: rtl/pid_pwm_out.sv
// PWM output stage: clamps the controller output, latches it into a shadow duty register at
// each period boundary and drives a registered high/low pair. Optional dead-time: PID_PWM_DEADTIME_EN.
module pid_pwm_out #(
  parameter int PERIOD = 15000,
  parameter int UK_W   = 17,
  parameter int CNT_W  = 14,
  parameter int DEAD   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [UK_W-1:0]  uk,
  output logic             pwm_h,
  output logic             pwm_l,
  output logic [CNT_W-1:0] duty,
  output logic             period_tick,
  output logic             sat
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] MAXD = CNT_W'(PERIOD);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] duty_q;
  logic             sat_q;
  logic             pwm_h_q, pwm_h_d;
  logic             pwm_l_q, pwm_l_d;
  logic [CNT_W-1:0] clamp_val;
  logic             clamp_flag;
  logic             boundary;
  logic             raw_h, raw_l;

  // Returns {clamped flag, duty value}; negative inputs are flagged and forced to zero.
  function automatic logic [CNT_W:0] clamp(input logic [UK_W-1:0] v);
    if (v[UK_W-1])
      return {1'b1, {CNT_W{1'b0}}};
    else if (v > UK_W'(PERIOD))
      return {1'b1, MAXD};
    else
      return {1'b0, v[CNT_W-1:0]};
  endfunction

  assign {clamp_flag, clamp_val} = clamp(uk);

  assign boundary = (state_q == RUN) && (cnt_q == LAST);
  assign raw_h    = (state_q == RUN) && (cnt_q < duty_q);
  assign raw_l    = (state_q == RUN) && !(cnt_q < duty_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      sat_q   <= 1'b0;
      pwm_h_q <= 1'b0;
      pwm_l_q <= 1'b0;
    end else begin
      pwm_h_q <= pwm_h_d;
      pwm_l_q <= pwm_l_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (en) begin
            state_q <= RUN;
            duty_q  <= clamp_val;
            sat_q   <= clamp_flag;
          end
        end
        RUN: begin
          // en is only honoured on the last cycle, so a run request always finishes its period
          if (boundary) begin
            cnt_q <= '0;
            if (en) begin
              duty_q <= clamp_val;
              sat_q  <= clamp_flag;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

`ifdef PID_PWM_DEADTIME_EN
  localparam int              DT_W   = (DEAD < 1) ? 1 : $clog2(DEAD + 1);
  localparam logic [DT_W-1:0] DEAD_V = DT_W'(DEAD);

  logic [1:0]      phase_q, phase_d;
  logic [DT_W-1:0] run_q, run_d;
  logic [DT_W-1:0] prior;

  // prior = cycles the current raw phase has already lasted, saturating at DEAD
  always_comb begin
    phase_d = {raw_h, raw_l};
    prior   = (phase_d == phase_q) ? run_q : '0;
    run_d   = (prior == DEAD_V) ? prior : prior + DT_W'(1);
    pwm_h_d = raw_h && (prior >= DEAD_V);
    pwm_l_d = raw_l && (prior >= DEAD_V);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (state_q == IDLE)) begin
      phase_q <= 2'b00;
      run_q   <= '0;
    end else begin
      phase_q <= phase_d;
      run_q   <= run_d;
    end
  end
`else
  assign pwm_h_d = raw_h;
  assign pwm_l_d = raw_l;
`endif

  assign pwm_h       = pwm_h_q;
  assign pwm_l       = pwm_l_q;
  assign duty        = duty_q;
  assign sat         = sat_q;
  assign period_tick = boundary;

endmodule

// File: tb/tb_pid_pwm_out.sv
// Scoreboard bench for pid_pwm_out: stimulus pushes per-period expectations, a negedge
// monitor measures each period window (duty, sat, high/low counts, length) and compares.
module tb_pid_pwm_out;
  localparam int PERIOD = 20;
  localparam int UK_W   = 17;
  localparam int CNT_W  = 5;
  localparam int DEAD   = 2;
`ifdef PID_PWM_DEADTIME_EN
  localparam bit DT = 1'b1;
`else
  localparam bit DT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [UK_W-1:0]  uk;
  logic             pwm_h, pwm_l, period_tick, sat;
  logic [CNT_W-1:0] duty;

  pid_pwm_out #(.PERIOD(PERIOD), .UK_W(UK_W), .CNT_W(CNT_W), .DEAD(DEAD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .uk(uk),
    .pwm_h(pwm_h), .pwm_l(pwm_l), .duty(duty), .period_tick(period_tick), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int sat;
    int h;
    int l;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input int s, input int h, input int l, input int g);
    exp_t e;
    e.duty = d; e.sat = s; e.h = h; e.l = l; e.gap = g;
    sb.push_back(e);
  endtask

  // Returns in the tick cycle, #1 after the edge, so inputs set now are latched at the boundary.
  task automatic wait_tick();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(posedge clk); #1;
      if (period_tick) got = 1'b1;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL tick_timeout: no period_tick within 60 cycles (t=%0t)", $time);
    end
  endtask

  // Window of a period = samples showing cnt 0..19, i.e. cnt=1..19 plus the first sample after the tick.
  int   hc = 0, lc = 0, gap = 0;
  bit   closing = 1'b0, ovl = 1'b0;
  int   tick_duty = 0, tick_sat = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      hc = 0; lc = 0; gap = 0; closing = 1'b0; ovl = 1'b0;
    end else begin
      hc  += int'(pwm_h);
      lc  += int'(pwm_l);
      gap += 1;
      if (pwm_h && pwm_l) ovl = 1'b1;
      if (closing) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: got unexpected period, expected none (t=%0t)", $time);
        end else begin
          cur = sb.pop_front();
          check("win_duty", tick_duty, cur.duty);
          check("win_sat", tick_sat, cur.sat);
          check("win_high", hc, cur.h);
          check("win_low", lc, cur.l);
          check("win_overlap", {31'd0, ovl}, 0);
          if (cur.gap != 0) check("win_len", gap, cur.gap);
        end
        hc = 0; lc = 0; gap = 0; closing = 1'b0; ovl = 1'b0;
      end
      if (period_tick) begin
        closing   = 1'b1;
        tick_duty = int'(duty);
        tick_sat  = int'(sat);
      end
    end
  end

  bit idle_bad;

  initial begin
    rst_n = 1'b0; en = 1'b1; uk = 17'd10;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_outs", {23'd0, pwm_h, pwm_l, duty, period_tick, sat}, 0);
    end
    push(10, 0, DT ? 8 : 10, DT ? 8 : 10, 0);
    push(10, 0, DT ? 8 : 10, DT ? 8 : 10, 20);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("start_duty", duty, 10);
    check("start_sat", sat, 0);
    wait_tick();
    wait_tick();

    // Negative input, then over-range input
    uk = 17'h1FFF6;
    push(0, 1, 0, 20, 20);
    wait_tick();
    uk = 17'd25;
    push(20, 1, DT ? 18 : 20, 0, 20);
    push(20, 1, 20, 0, 20);
    @(posedge clk); #1;
    check("ovr_duty", duty, 20);
    check("ovr_sat", sat, 1);
    wait_tick();
    wait_tick();

    // Mid-period uk change must wait for the next boundary
    uk = 17'd5;
    push(5, 0, 5, DT ? 13 : 15, 20);
    repeat (8) @(posedge clk); #1;
    check("mid_duty_before", duty, 5);
    uk = 17'd15;
    push(15, 0, DT ? 13 : 15, DT ? 3 : 5, 20);
    wait_tick();
    check("mid_duty_tick", duty, 5);

    // Drop en at cnt=3: period completes, then IDLE
    repeat (4) @(posedge clk); #1;
    check("mid_duty_after", duty, 15);
    en = 1'b0;
    wait_tick();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idle_outs", {29'd0, pwm_h, pwm_l, period_tick}, 0);
    idle_bad = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (pwm_h || pwm_l || period_tick) idle_bad = 1'b1;
    end
    check("idle_quiet", {31'd0, idle_bad}, 0);
    check("idle_duty_kept", duty, 15);
    check("idle_sat_kept", sat, 0);

    // Restart, then a one-cycle reset pulse at cnt=12
    uk = 17'd8; en = 1'b1;
    @(posedge clk); #1;
    check("restart_duty", duty, 8);
    repeat (12) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_outs", {23'd0, pwm_h, pwm_l, duty, period_tick, sat}, 0);
    uk = 17'd12;
    push(12, 0, DT ? 10 : 12, DT ? 6 : 8, 0);
    push(12, 0, DT ? 10 : 12, DT ? 6 : 8, 20);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_restart_duty", duty, 12);
    wait_tick();
    wait_tick();

    // Short duty: swallowed entirely by dead-time when enabled
    uk = 17'd2;
    push(2, 0, DT ? 0 : 2, DT ? 16 : 18, 20);
    push(2, 0, DT ? 0 : 2, DT ? 16 : 18, 20);
    wait_tick();
    wait_tick();
    en = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
